// File: rtl/axi_master_arbiter.sv
// -----------------------------------------------------------------------------
// axi_master_arbiter
//   Round-robin arbiter for an N-master AXI interconnect (N = 2**M_WIDTH).
//   The AW and AR address channels each run an independent ARB/GRANT FSM.
//   A write-order FIFO remembers which master won each AW handshake, so the
//   W channel is switched to masters in address order. B and R responses are
//   routed by decoding the master index carried in the upper ID bits.
//
// Ports
//   clk, rstn                     clock, asynchronous active-low reset
//   MASTER_WR_ADDR_VALID [N]      per-master AW valid
//   MASTER_RD_ADDR_VALID [N]      per-master AR valid
//   BUS_WR_ADDR_VALID/READY       switched AW handshake
//   BUS_WR_DATA_VALID/READY/LAST  switched W handshake
//   BUS_WR_BACK_ID                B-channel ID  (master index in top M_WIDTH bits)
//   BUS_RD_ADDR_VALID/READY       switched AR handshake
//   BUS_RD_BACK_ID                R-channel ID  (master index in top M_WIDTH bits)
//   wr_addr_sel, wr_data_sel, wr_resp_sel, rd_addr_sel, rd_data_sel
//                                 switch selects
//   wr_addr_en, wr_data_en, rd_addr_en
//                                 grant active (integrator ANDs with VALID/READY)
//   wr_outstanding                write-order FIFO occupancy
// -----------------------------------------------------------------------------

// One address-channel arbiter: ARB (en=0) -> GRANT (en=1, sel frozen) -> ARB.
module axi_master_arbiter_chan #(
    parameter int M_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [2**M_WIDTH-1:0]   req,
    input  logic                    allow,
    input  logic                    bus_valid,
    input  logic                    bus_ready,
    output logic                    en,
    output logic [M_WIDTH-1:0]      sel,
    output logic                    handshake
);
    localparam int N = 2**M_WIDTH;

    typedef enum logic {ARB, GRANT} state_t;

    state_t             state, state_nxt;
    logic [M_WIDTH-1:0] sel_nxt;
    logic [M_WIDTH-1:0] last_granted, last_granted_nxt;
    logic [M_WIDTH-1:0] winner;
    logic [M_WIDTH-1:0] cand;
    logic               found;

    // Round-robin search starting just after the last winner. The M_WIDTH-bit
    // addition wraps modulo N, so i = N lands back on last_granted itself.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand = last_granted + M_WIDTH'(i);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so no path can leave a signal unassigned (no latch).
    always_comb begin
        state_nxt        = state;
        sel_nxt          = sel;
        last_granted_nxt = last_granted;
        handshake        = 1'b0;
        case (state)
            ARB: begin
                if (found && allow) begin
                    state_nxt = GRANT;
                    sel_nxt   = winner;
                end
            end
            GRANT: begin
                // A master dropping VALID mid-grant is ignored: only the bus
                // handshake releases the grant.
                if (bus_valid && bus_ready) begin
                    handshake        = 1'b1;
                    last_granted_nxt = sel;
                    state_nxt        = ARB;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ARB;
            sel          <= '0;
            last_granted <= '1;   // N-1, so master 0 wins the first search
        end else begin
            state        <= state_nxt;
            sel          <= sel_nxt;
            last_granted <= last_granted_nxt;
        end
    end

    assign en = (state == GRANT);
endmodule

module axi_master_arbiter #(
    parameter int M_WIDTH       = 2,
    parameter int M_ID          = 2,
    parameter int WR_FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [2**M_WIDTH-1:0]         MASTER_WR_ADDR_VALID,
    input  logic [2**M_WIDTH-1:0]         MASTER_RD_ADDR_VALID,
    input  logic                          BUS_WR_ADDR_VALID,
    input  logic                          BUS_WR_ADDR_READY,
    input  logic                          BUS_WR_DATA_VALID,
    input  logic                          BUS_WR_DATA_READY,
    input  logic                          BUS_WR_DATA_LAST,
    input  logic [M_ID+M_WIDTH-1:0]       BUS_WR_BACK_ID,
    input  logic                          BUS_RD_ADDR_VALID,
    input  logic                          BUS_RD_ADDR_READY,
    input  logic [M_ID+M_WIDTH-1:0]       BUS_RD_BACK_ID,
    output logic [M_WIDTH-1:0]            wr_addr_sel,
    output logic [M_WIDTH-1:0]            wr_data_sel,
    output logic [M_WIDTH-1:0]            wr_resp_sel,
    output logic [M_WIDTH-1:0]            rd_addr_sel,
    output logic [M_WIDTH-1:0]            rd_data_sel,
    output logic                          wr_addr_en,
    output logic                          wr_data_en,
    output logic                          rd_addr_en,
    output logic [$clog2(WR_FIFO_DEPTH):0] wr_outstanding
);
    localparam int PW = $clog2(WR_FIFO_DEPTH);

    logic          aw_allow;
    logic          aw_handshake;
    logic          ar_handshake;
    logic          push, pop;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [M_WIDTH-1:0] order_mem [WR_FIFO_DEPTH];

    // A new AW grant is only started while the order FIFO has room; the one
    // grant in flight can then always push, so the FIFO never overflows.
    assign aw_allow = (count < (PW+1)'(WR_FIFO_DEPTH));

    axi_master_arbiter_chan #(.M_WIDTH(M_WIDTH)) u_aw (
        .clk       (clk),
        .rstn      (rstn),
        .req       (MASTER_WR_ADDR_VALID),
        .allow     (aw_allow),
        .bus_valid (BUS_WR_ADDR_VALID),
        .bus_ready (BUS_WR_ADDR_READY),
        .en        (wr_addr_en),
        .sel       (wr_addr_sel),
        .handshake (aw_handshake)
    );

    axi_master_arbiter_chan #(.M_WIDTH(M_WIDTH)) u_ar (
        .clk       (clk),
        .rstn      (rstn),
        .req       (MASTER_RD_ADDR_VALID),
        .allow     (1'b1),
        .bus_valid (BUS_RD_ADDR_VALID),
        .bus_ready (BUS_RD_ADDR_READY),
        .en        (rd_addr_en),
        .sel       (rd_addr_sel),
        .handshake (ar_handshake)
    );

    // Write-order FIFO: one entry per accepted AW, retired by the W LAST beat.
    assign push = aw_handshake;
    assign pop  = wr_data_en && BUS_WR_DATA_VALID && BUS_WR_DATA_READY && BUS_WR_DATA_LAST;

    // NOTE: the storage array has no reset; the pointers and count define which
    // entries are valid, so clearing them alone empties the FIFO.
    always_ff @(posedge clk) begin
        if (push) order_mem[wr_ptr] <= wr_addr_sel;
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head is read straight from storage: a push into an empty FIFO shows up
    // one cycle later, never in the same cycle.
    assign wr_data_sel    = order_mem[rd_ptr];
    assign wr_data_en     = (count != '0);
    assign wr_outstanding = count;

    // Responses carry the master index in their ID; no read-side state kept.
    assign wr_resp_sel = BUS_WR_BACK_ID[M_ID +: M_WIDTH];
    assign rd_data_sel = BUS_RD_BACK_ID[M_ID +: M_WIDTH];

    logic unused_id_bits;
    assign unused_id_bits = ^{BUS_WR_BACK_ID[M_ID-1:0], BUS_RD_BACK_ID[M_ID-1:0], ar_handshake};
endmodule
